// File: rtl/display_arbiter.sv
// Two-requester round-robin arbiter for a 4-digit hex display with a minimum grant hold time.
// Optional leading-zero blanking is enabled by defining DISPLAY_ARBITER_LZB_EN.
module display_arbiter #(
    parameter int HOLD_CYCLES = 1024,
    parameter int CNT_W       = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_req0,
    input  logic [15:0] i_value0,
    input  logic [3:0]  i_mask0,
    input  logic        i_req1,
    input  logic [15:0] i_value1,
    input  logic [3:0]  i_mask1,
    output logic [1:0]  o_grant,
    output logic [3:0]  o_digit1,
    output logic [3:0]  o_digit2,
    output logic [3:0]  o_digit3,
    output logic [3:0]  o_digit4,
    output logic        o_show_digit1,
    output logic        o_show_digit2,
    output logic        o_show_digit3,
    output logic        o_show_digit4
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] HOLD_MAX = CNT_W'(HOLD_CYCLES - 1);

    state_t           state, state_next;
    logic [CNT_W-1:0] hold_cnt, hold_cnt_next;
    logic             rr_ptr, rr_ptr_next;
    logic             hold_done;

    logic [1:0]       grant_next;
    logic [15:0]      value_sel;
    logic [3:0]       mask_sel;
    logic [3:0]       show_next;
    logic [3:0]       blank;

    assign hold_done = (hold_cnt == HOLD_MAX);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            hold_cnt <= '0;
            rr_ptr   <= 1'b0;
        end else begin
            state    <= state_next;
            hold_cnt <= hold_cnt_next;
            rr_ptr   <= rr_ptr_next;
        end
    end

    // rr_ptr names the requester that wins a tie: the one not granted most recently.
    always_comb begin
        state_next    = state;
        hold_cnt_next = hold_cnt;
        rr_ptr_next   = rr_ptr;
        case (state)
            IDLE: begin
                if (i_req0 && i_req1)
                    state_next = rr_ptr ? OWN1 : OWN0;
                else if (i_req0)
                    state_next = OWN0;
                else if (i_req1)
                    state_next = OWN1;
            end
            OWN0: begin
                if (hold_done) begin
                    if (i_req1)
                        state_next = OWN1;
                    else if (!i_req0)
                        state_next = IDLE;
                end
            end
            OWN1: begin
                if (hold_done) begin
                    if (i_req0)
                        state_next = OWN0;
                    else if (!i_req1)
                        state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase

        if (state_next == IDLE) begin
            hold_cnt_next = '0;
        end else if (state_next != state) begin
            hold_cnt_next = '0;
            rr_ptr_next   = (state_next == OWN0);
        end else if (!hold_done) begin
            hold_cnt_next = hold_cnt + CNT_W'(1);
        end
    end

    // Outputs follow the upcoming owner so data and grant switch on the same edge.
    always_comb begin
        grant_next = 2'b00;
        value_sel  = 16'h0000;
        mask_sel   = 4'h0;
        case (state_next)
            OWN0: begin
                grant_next = 2'b01;
                value_sel  = i_value0;
                mask_sel   = i_mask0;
            end
            OWN1: begin
                grant_next = 2'b10;
                value_sel  = i_value1;
                mask_sel   = i_mask1;
            end
            default: ;
        endcase

`ifdef DISPLAY_ARBITER_LZB_EN
        blank[3] = (value_sel[15:12] == 4'h0);
        blank[2] = blank[3] && (value_sel[11:8] == 4'h0);
        blank[1] = blank[2] && (value_sel[7:4] == 4'h0);
        blank[0] = 1'b0;
`else
        blank = 4'h0;
`endif
        show_next = mask_sel & ~blank;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            o_grant       <= 2'b00;
            o_digit1      <= 4'h0;
            o_digit2      <= 4'h0;
            o_digit3      <= 4'h0;
            o_digit4      <= 4'h0;
            o_show_digit1 <= 1'b0;
            o_show_digit2 <= 1'b0;
            o_show_digit3 <= 1'b0;
            o_show_digit4 <= 1'b0;
        end else begin
            o_grant       <= grant_next;
            o_digit1      <= value_sel[3:0];
            o_digit2      <= value_sel[7:4];
            o_digit3      <= value_sel[11:8];
            o_digit4      <= value_sel[15:12];
            o_show_digit1 <= show_next[0];
            o_show_digit2 <= show_next[1];
            o_show_digit3 <= show_next[2];
            o_show_digit4 <= show_next[3];
        end
    end

endmodule

// File: tb/tb_display_arbiter.sv
// Self-checking bench for display_arbiter: directed scenarios plus randomized traffic
// compared against a behavioural owner/hold/round-robin model.
module tb_display_arbiter;

    localparam int HOLD = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req0 = 1'b0, req1 = 1'b0;
    logic [15:0] value0 = '0, value1 = '0;
    logic [3:0]  mask0 = '0, mask1 = '0;
    logic [1:0]  grant;
    logic [3:0]  d1, d2, d3, d4;
    logic        s1, s2, s3, s4;

    int checks = 0;
    int errors = 0;

    int          m_owner;
    int          m_held;
    int          m_ptr;
    logic [15:0] m_value;
    logic [3:0]  m_mask;

    display_arbiter #(.HOLD_CYCLES(HOLD), .CNT_W(3)) dut (
        .clk(clk), .rst(rst),
        .i_req0(req0), .i_value0(value0), .i_mask0(mask0),
        .i_req1(req1), .i_value1(value1), .i_mask1(mask1),
        .o_grant(grant),
        .o_digit1(d1), .o_digit2(d2), .o_digit3(d3), .o_digit4(d4),
        .o_show_digit1(s1), .o_show_digit2(s2), .o_show_digit3(s3), .o_show_digit4(s4)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [15:0] observed, input logic [15:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: observed %h expected %h at %0t", tag, observed, expected, $time);
        end
    endtask

    // Show bits: mask, and (with blanking) only digits at or below the most significant nonzero one.
    function automatic logic [3:0] expShow(input logic [15:0] value, input logic [3:0] mask);
        logic [3:0] s;
        int top;
        s = mask;
`ifdef DISPLAY_ARBITER_LZB_EN
        top = 1;
        for (int n = 1; n <= 4; n++)
            if (value[4*n-1 -: 4] != 4'h0) top = n;
        for (int n = 1; n <= 4; n++)
            if (n > top) s[n-1] = 1'b0;
`endif
        return s;
    endfunction

    task automatic modelReset();
        m_owner = 0;
        m_held  = 0;
        m_ptr   = 0;
        m_value = '0;
        m_mask  = '0;
    endtask

    // Owner: 0 idle, 1 requester 0, 2 requester 1. m_held counts cycles already owned.
    task automatic modelStep();
        int nxt;
        logic mine, other;
        nxt = m_owner;
        if (m_owner == 0) begin
            if (req0 && req1) nxt = m_ptr + 1;
            else if (req0)    nxt = 1;
            else if (req1)    nxt = 2;
        end else begin
            mine  = (m_owner == 1) ? req0 : req1;
            other = (m_owner == 1) ? req1 : req0;
            if (m_held < HOLD - 1) m_held++;
            else if (other)        nxt = 3 - m_owner;
            else if (!mine)        nxt = 0;
        end
        if (nxt != 0 && nxt != m_owner) begin
            m_held = 0;
            m_ptr  = (nxt == 1) ? 1 : 0;
        end
        m_owner = nxt;
        if (nxt == 1) begin
            m_value = value0; m_mask = mask0;
        end else if (nxt == 2) begin
            m_value = value1; m_mask = mask1;
        end else begin
            m_value = '0; m_mask = '0;
        end
    endtask

    task automatic checkAll();
        logic [15:0] exp_grant;
        exp_grant = (m_owner == 1) ? 16'd1 : (m_owner == 2) ? 16'd2 : 16'd0;
        checkOutput("grant", 16'(grant), exp_grant);
        checkOutput("digits", {d4, d3, d2, d1}, m_value);
        checkOutput("shows", 16'({s4, s3, s2, s1}), 16'(expShow(m_value, m_mask)));
    endtask

    task automatic applyStimulus(input logic r0, input logic r1,
                                 input logic [15:0] v0, input logic [3:0] k0,
                                 input logic [15:0] v1, input logic [3:0] k1);
        req0 = r0; req1 = r1;
        value0 = v0; mask0 = k0;
        value1 = v1; mask1 = k1;
    endtask

    task automatic runCycle();
        @(posedge clk);
        modelStep();
        @(negedge clk);
        checkAll();
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_grant"}, 16'(grant), 16'h0000);
        checkOutput({tag, "_digits"}, {d4, d3, d2, d1}, 16'h0000);
        checkOutput({tag, "_shows"}, 16'({s4, s3, s2, s1}), 16'h0000);
    endtask

    initial begin
        logic r0, r1;
        int wait_cycles;
        modelReset();
        #1 rst = 1'b0;
        #2 checkAllZero("reset");
        @(negedge clk);
        rst = 1'b1;

        // Single requester grant and data latency.
        applyStimulus(1'b1, 1'b0, 16'h1234, 4'hF, 16'h0000, 4'h0);
        runCycle();
        checkOutput("req026_grant", 16'(grant), 16'h0001);
        runCycle();
        checkOutput("req026_digits", {d4, d3, d2, d1}, 16'h1234);
        checkOutput("req026_shows", 16'({s4, s3, s2, s1}), 16'h000F);

        // Blanking patterns on the owned value.
        applyStimulus(1'b1, 1'b0, 16'h0050, 4'hF, 16'h0000, 4'h0);
        runCycle();
        applyStimulus(1'b1, 1'b0, 16'h0000, 4'hF, 16'h0000, 4'h0);
        runCycle();
        applyStimulus(1'b1, 1'b0, 16'h0A00, 4'h5, 16'h0000, 4'h0);
        runCycle();

        // Second requester arrives: hold then direct switch, then release to idle.
        applyStimulus(1'b1, 1'b1, 16'h0A00, 4'h5, 16'hBEEF, 4'hE);
        for (int i = 0; i < 2 * HOLD + 2; i++) runCycle();
        applyStimulus(1'b0, 1'b0, 16'h1111, 4'hF, 16'h2222, 4'hF);
        for (int i = 0; i < HOLD + 1; i++) runCycle();
        checkOutput("idle_grant", 16'(grant), 16'h0000);

        // Async reset in the middle of a requester 1 hold.
        applyStimulus(1'b0, 1'b1, 16'h0000, 4'h0, 16'h9876, 4'hF);
        runCycle();
        checkOutput("own1_grant", 16'(grant), 16'h0002);
        #2 rst = 1'b0;
        #1 checkAllZero("midreset");
        modelReset();
        @(negedge clk);
        rst = 1'b1;
        runCycle();
        checkOutput("postreset_grant", 16'(grant), 16'h0002);

        // Both requesters from reset: alternation through the round-robin pointer.
        @(negedge clk);
        rst = 1'b0;
        modelReset();
        #1 rst = 1'b1;
        applyStimulus(1'b1, 1'b1, 16'h00C3, 4'hB, 16'h7000, 4'h9);
        runCycle();
        checkOutput("rr_first", 16'(grant), 16'h0001);
        wait_cycles = 0;
        while (grant != 2'b10 && wait_cycles < 3 * HOLD) begin
            runCycle();
            wait_cycles++;
        end
        checkOutput("rr_second", 16'(grant), 16'h0002);
        for (int i = 0; i < HOLD; i++) runCycle();
        checkOutput("rr_third", 16'(grant), 16'h0001);

        // Randomized traffic with sticky requests.
        r0 = 1'b0;
        r1 = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 3) == 0) r0 = ~r0;
            if ($urandom_range(0, 3) == 0) r1 = ~r1;
            applyStimulus(r0, r1,
                          16'($urandom) & ($urandom_range(0, 1) ? 16'hFFFF : 16'h00FF),
                          4'($urandom),
                          16'($urandom) & ($urandom_range(0, 1) ? 16'hFFFF : 16'h000F),
                          4'($urandom));
            runCycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
